// File: rtl/com_cs_arq_if.sv
// Handshake and data bundle between com_cs_arq and its send client, packet reader and TX/RX engines.
// master = the controller, slave = everything around it.
interface com_cs_arq_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12
);
    logic              fs_send;
    logic              fd_send;
    logic              send_ok;
    logic [7:0]        send_retry;
    logic [3:0]        send_btype;
    logic [LEN_W-1:0]  send_dlen;
    logic [ADDR_W-1:0] ram_addr_init;
    logic              fs_read;
    logic              fd_read;
    logic [3:0]        read_btype;
    logic              rd_abort;
    logic              fs_tx;
    logic              fd_tx;
    logic              fs_rx;
    logic              fd_rx;
    logic [3:0]        tx_btype;
    logic [ADDR_W-1:0] tx_ram_init;
    logic [LEN_W-1:0]  tx_ram_rlen;
    logic [3:0]        rx_btype;

    modport master (
        input  fs_send, send_btype, send_dlen, ram_addr_init, fd_read, fd_tx, fs_rx, rx_btype,
        output fd_send, send_ok, send_retry, fs_read, read_btype, rd_abort,
               fs_tx, fd_rx, tx_btype, tx_ram_init, tx_ram_rlen
    );

    modport slave (
        output fs_send, send_btype, send_dlen, ram_addr_init, fd_read, fd_tx, fs_rx, rx_btype,
        input  fd_send, send_ok, send_retry, fs_read, read_btype, rd_abort,
               fs_tx, fd_rx, tx_btype, tx_ram_init, tx_ram_rlen
    );
endinterface

// File: rtl/com_cs_arq.sv
// Link-layer ARQ controller: sends with ACK/NAK/timeout retransmission, qualifies and answers RX packets.
// Define COM_CS_ARQ_DUP_FILTER_EN to suppress delivery of a repeated DATA0/DATA1 sequence bit.
module com_cs_arq #(
    parameter int ADDR_W       = 12,
    parameter int LEN_W        = 12,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 128,
    parameter int READ_TIMEOUT = 128,
    parameter int RETRY_MAX    = 16
) (
    input  logic          clk,
    input  logic          rst,
    com_cs_arq_if.master  bus
);
    localparam logic [3:0] PKT_ACK   = 4'b0001;
    localparam logic [3:0] PKT_NAK   = 4'b0010;
    localparam logic [3:0] PKT_DATA0 = 4'b1101;
    localparam logic [3:0] PKT_DATA1 = 4'b1110;
    localparam logic [3:0] PKT_ERROR = 4'b1111;

    localparam logic [CNT_W-1:0] ANS_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_LIM = 8'(RETRY_MAX);

    typedef enum logic [3:0] {
        IDLE, WAIT, SEND_PREP, SEND_DATA, RANS_WAIT, RANS_TAKE, RANS_DONE,
        SEND_DONE, READ_PREP, READ_DATA, WANS_PREP, WANS_DONE, READ_DONE, READ_ABORT
    } state_t;

    state_t            state, nxt;
    logic [CNT_W-1:0]  timer;
    logic [3:0]        tx_btype_q, read_btype_q;
    logic [ADDR_W-1:0] tx_init_q;
    logic [LEN_W-1:0]  tx_len_q;
    logic [7:0]        retry_q, nak_q;
    logic              ok_q;
    logic              goto_retx;
    logic              ans_timeout, retry_left, dup_hit;

    assign ans_timeout = timer >= ANS_LAST;
    assign retry_left  = retry_q < RETRY_LIM;

`ifdef COM_CS_ARQ_DUP_FILTER_EN
    localparam logic [1:0] SEQ_NONE = 2'd0;
    localparam logic [1:0] SEQ_D0   = 2'd1;
    localparam logic [1:0] SEQ_D1   = 2'd2;

    logic [1:0] last_seq, rd_seq;

    always_comb begin
        rd_seq = SEQ_NONE;
        if (read_btype_q == PKT_DATA0)      rd_seq = SEQ_D0;
        else if (read_btype_q == PKT_DATA1) rd_seq = SEQ_D1;
    end

    assign dup_hit = (rd_seq != SEQ_NONE) && (rd_seq == last_seq);

    // Only packets actually handed to the reader advance the sequence history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_seq <= SEQ_NONE;
        else if (state == WANS_DONE && bus.fd_tx && tx_btype_q == PKT_ACK
                 && !dup_hit && rd_seq != SEQ_NONE)
            last_seq <= rd_seq;
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:       nxt = WAIT;
            WAIT:       nxt = bus.fs_send ? SEND_PREP : (bus.fs_rx ? READ_PREP : WAIT);
            SEND_PREP:  nxt = SEND_DATA;
            SEND_DATA:  nxt = bus.fd_tx ? RANS_WAIT : SEND_DATA;
            RANS_WAIT: begin
                // Timeout is tested first so an answer landing on the last cycle is dropped.
                if (ans_timeout)    nxt = retry_left ? SEND_DATA : SEND_DONE;
                else if (bus.fs_rx) nxt = RANS_TAKE;
                else                nxt = RANS_WAIT;
            end
            RANS_TAKE:  nxt = RANS_DONE;
            RANS_DONE:  nxt = bus.fs_rx ? RANS_DONE : (goto_retx ? SEND_DATA : SEND_DONE);
            SEND_DONE:  nxt = bus.fs_send ? SEND_DONE : WAIT;
            READ_PREP:  nxt = READ_DATA;
            READ_DATA:  nxt = bus.fs_rx ? READ_DATA : WANS_PREP;
            WANS_PREP:  nxt = WANS_DONE;
            WANS_DONE: begin
                if (!bus.fd_tx)                                nxt = WANS_DONE;
                else if (tx_btype_q == PKT_NAK || dup_hit)     nxt = WAIT;
                else                                           nxt = READ_DONE;
            end
            READ_DONE: begin
                if (bus.fd_read)            nxt = WAIT;
                else if (timer >= READ_LAST) nxt = READ_ABORT;
                else                        nxt = READ_DONE;
            end
            READ_ABORT: nxt = WAIT;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.fs_tx    = 1'b0;
        bus.fd_rx    = 1'b0;
        bus.fd_send  = 1'b0;
        bus.fs_read  = 1'b0;
        bus.rd_abort = 1'b0;
        case (state)
            SEND_DATA, WANS_DONE: bus.fs_tx    = 1'b1;
            READ_DATA, RANS_DONE: bus.fd_rx    = 1'b1;
            SEND_DONE:            bus.fd_send  = 1'b1;
            READ_DONE:            bus.fs_read  = 1'b1;
            READ_ABORT:           bus.rd_abort = 1'b1;
            default: ;
        endcase
    end

    assign bus.send_ok     = ok_q;
    assign bus.send_retry  = retry_q;
    assign bus.read_btype  = read_btype_q;
    assign bus.tx_btype    = tx_btype_q;
    assign bus.tx_ram_init = tx_init_q;
    assign bus.tx_ram_rlen = tx_len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer        <= '0;
            tx_btype_q   <= '0;
            tx_init_q    <= '0;
            tx_len_q     <= '0;
            read_btype_q <= '0;
            retry_q      <= '0;
            nak_q        <= '0;
            ok_q         <= 1'b0;
            goto_retx    <= 1'b0;
        end else begin
            timer <= (state == RANS_WAIT || state == READ_DONE) ? timer + 1'b1 : '0;
            case (state)
                WAIT: begin
                    tx_btype_q   <= '0;
                    tx_init_q    <= '0;
                    tx_len_q     <= '0;
                    read_btype_q <= '0;
                    retry_q      <= '0;
                    nak_q        <= '0;
                end
                SEND_PREP: begin
                    tx_btype_q <= bus.send_btype;
                    tx_init_q  <= bus.ram_addr_init;
                    tx_len_q   <= bus.send_dlen;
                    retry_q    <= '0;
                    ok_q       <= 1'b0;
                end
                RANS_WAIT: begin
                    if (ans_timeout && retry_left) retry_q <= retry_q + 1'b1;
                end
                RANS_TAKE: begin
                    ok_q      <= (bus.rx_btype == PKT_ACK);
                    goto_retx <= (bus.rx_btype == PKT_NAK) && retry_left;
                    if (bus.rx_btype == PKT_NAK && retry_left) retry_q <= retry_q + 1'b1;
                end
                WANS_PREP: begin
                    read_btype_q <= bus.rx_btype;
                    if (bus.rx_btype == PKT_ERROR && nak_q < RETRY_LIM) begin
                        tx_btype_q <= PKT_NAK;
                        nak_q      <= nak_q + 1'b1;
                    end else begin
                        tx_btype_q <= PKT_ACK;
                        nak_q      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_com_cs_arq.sv
// Drives com_cs_arq as send client, TX/RX engines and packet reader; checks against a transaction-level model.
module tb_com_cs_arq;
    localparam int AW = 12, LW = 12, TO = 16, RTO = 8, RMAX = 3;
    localparam logic [3:0] INIT = 4'b0000, ACK = 4'b0001, NAK = 4'b0010;
    localparam logic [3:0] DATA0 = 4'b1101, DATA1 = 4'b1110, ERROR = 4'b1111;
    // Answer given to each transmission attempt; LATE = fs_rx only on the timeout cycle.
    localparam int A_NONE = 0, A_ACK = 1, A_NAK = 2, A_OTHER = 3, A_LATE = 4;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    int         ans_q[$];
    logic [3:0] last_data_m;
    int         na, n;
    logic [3:0] rt;

    com_cs_arq_if #(.ADDR_W(AW), .LEN_W(LW)) bus();

    com_cs_arq #(
        .ADDR_W(AW), .LEN_W(LW), .CNT_W(16),
        .TIMEOUT(TO), .READ_TIMEOUT(RTO), .RETRY_MAX(RMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({bus.fs_tx, bus.fd_rx, bus.fd_send, bus.fs_read, bus.rd_abort, bus.send_ok}), 32'd0);
        check({tag, "_retry"}, 32'(bus.send_retry), 32'd0);
        check({tag, "_tx"}, 32'({bus.tx_btype, bus.tx_ram_init, bus.tx_ram_rlen}), 32'd0);
        check({tag, "_read_btype"}, 32'(bus.read_btype), 32'd0);
    endtask

    task automatic wait_fd_rx(input string tag);
        int k;
        k = 0;
        while (!bus.fd_rx && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_fd_rx_seen"}, 32'(bus.fd_rx), 32'd1);
    endtask

    task automatic do_send(input string tag, input logic [3:0] bt,
                           input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int   exp_tx, exp_retry, n_tx, lat, lows, code, d;
        logic exp_ok;
        bit   fin;
        // Reference: walk the answers; each NAK/timeout costs one retry until the budget is spent.
        exp_tx = 0; exp_retry = 0; exp_ok = 1'b0;
        for (int a = 0; a < 64; a++) begin
            code = (a < ans_q.size()) ? ans_q[a] : A_NONE;
            exp_tx++;
            if (code == A_ACK) begin exp_ok = 1'b1; break; end
            if (code == A_OTHER) break;
            if (exp_retry >= RMAX) break;
            exp_retry++;
        end

        bus.fs_send = 1'b1; bus.send_btype = bt; bus.ram_addr_init = addr; bus.send_dlen = len;
        n_tx = 0; fin = 1'b0;
        for (int a = 0; a < 64 && !fin; a++) begin
            lat = 0;
            while (!bus.fs_tx && !bus.fd_send && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            if (a == 0) check({tag, "_start_latency"}, 32'(lat), 32'd2);
            if (!bus.fs_tx) fin = 1'b1;
            else begin
                n_tx++;
                check({tag, "_tx_btype"}, 32'(bus.tx_btype), 32'(bt));
                check({tag, "_tx_ram_init"}, 32'(bus.tx_ram_init), 32'(addr));
                check({tag, "_tx_ram_rlen"}, 32'(bus.tx_ram_rlen), 32'(len));
                code = (a < ans_q.size()) ? ans_q[a] : A_NONE;
                bus.fd_tx = 1'b1;
                @(negedge clk);
                bus.fd_tx = 1'b0;
                if (code == A_ACK || code == A_NAK || code == A_OTHER) begin
                    // Answer anywhere in the window, including its final cycle.
                    d = ($urandom_range(0, 3) == 0) ? TO - 2 : int'($urandom_range(0, TO - 2));
                    repeat (d) @(negedge clk);
                    bus.rx_btype = (code == A_ACK) ? ACK : ((code == A_NAK) ? NAK : DATA0);
                    bus.fs_rx = 1'b1;
                    wait_fd_rx(tag);
                    bus.fs_rx = 1'b0;
                    @(negedge clk);
                end else begin
                    lows = 0;
                    while (!bus.fs_tx && !bus.fd_send && lows < 100) begin
                        if (code == A_LATE && lows == TO - 1) begin
                            bus.rx_btype = ACK;
                            bus.fs_rx = 1'b1;
                        end
                        @(negedge clk);
                        bus.fs_rx = 1'b0;
                        lows++;
                    end
                    check({tag, "_answer_window"}, 32'(lows), 32'(TO));
                end
            end
        end
        check({tag, "_fd_send"}, 32'(bus.fd_send), 32'd1);
        check({tag, "_n_tx"}, 32'(n_tx), 32'(exp_tx));
        check({tag, "_send_ok"}, 32'(bus.send_ok), 32'(exp_ok));
        check({tag, "_send_retry"}, 32'(bus.send_retry), 32'(exp_retry));
        bus.fs_send = 1'b0;
        @(negedge clk);
        check({tag, "_fd_send_drop"}, 32'(bus.fd_send), 32'd0);
        ans_q.delete();
    endtask

    task automatic do_read(input string tag, input logic [3:0] t, input bit hold);
        logic [3:0] exp_ans;
        bit         deliver;
        int         k;
        // The consecutive-NAK count restarts at every WAIT, so an ERROR is NAKed whenever the budget is non-zero.
        exp_ans = (t == ERROR && RMAX > 0) ? NAK : ACK;
        deliver = (exp_ans == ACK);
`ifdef COM_CS_ARQ_DUP_FILTER_EN
        if (deliver && (t == DATA0 || t == DATA1) && t == last_data_m) deliver = 1'b0;
`endif
        if (deliver && (t == DATA0 || t == DATA1)) last_data_m = t;

        bus.rx_btype = t;
        bus.fs_rx = 1'b1;
        wait_fd_rx(tag);
        bus.fs_rx = 1'b0;
        k = 0;
        while (!bus.fs_tx && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_answer_fs_tx"}, 32'(bus.fs_tx), 32'd1);
        check({tag, "_answer_type"}, 32'(bus.tx_btype), 32'(exp_ans));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.fd_tx = 1'b1;
        @(negedge clk);
        bus.fd_tx = 1'b0;
        check({tag, "_fs_read"}, 32'(bus.fs_read), 32'(deliver));
        if (deliver) begin
            check({tag, "_read_btype"}, 32'(bus.read_btype), 32'(t));
            if (hold) begin
                k = 0;
                while (bus.fs_read && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check({tag, "_read_window"}, 32'(k), 32'(RTO));
                check({tag, "_rd_abort"}, 32'(bus.rd_abort), 32'd1);
                @(negedge clk);
                check({tag, "_rd_abort_pulse"}, 32'({bus.rd_abort, bus.fs_read}), 32'd0);
            end else begin
                repeat ($urandom_range(0, RTO - 2)) @(negedge clk);
                bus.fd_read = 1'b1;
                @(negedge clk);
                bus.fd_read = 1'b0;
                check({tag, "_fs_read_drop"}, 32'({bus.fs_read, bus.rd_abort}), 32'd0);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.fs_send = 1'b0; bus.send_btype = '0; bus.send_dlen = '0; bus.ram_addr_init = '0;
        bus.fd_read = 1'b0; bus.fd_tx = 1'b0; bus.fs_rx = 1'b0; bus.rx_btype = '0;
        last_data_m = INIT;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        ans_q = '{A_ACK};                      do_send("basic", DATA0, 12'h100, 12'h040);
        ans_q = '{A_NAK, A_NAK, A_ACK};        do_send("nak_retry", DATA1, 12'h2a0, 12'h010);
        ans_q = '{A_LATE};                     do_send("timeout", DATA0, 12'h00f, 12'h3ff);
        ans_q = '{A_NAK, A_NAK, A_NAK, A_NAK}; do_send("nak_exhaust", INIT, 12'hfff, 12'h001);
        ans_q = '{A_NAK, A_OTHER};             do_send("other_ans", DATA1, 12'h321, 12'h123);
        ans_q = '{A_NONE, A_ACK};              do_send("timeout_then_ack", ERROR, 12'h0ab, 12'h0cd);

        do_read("rx_error", ERROR, 1'b0);
        do_read("rx_data0", DATA0, 1'b0);
        do_read("rx_abort", DATA1, 1'b1);
        do_read("dup_d0", DATA0, 1'b0);
        do_read("dup_d1a", DATA1, 1'b0);
        do_read("dup_d1b", DATA1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                na = int'($urandom_range(1, 5));
                ans_q.delete();
                for (int j = 0; j < na; j++) ans_q.push_back(int'($urandom_range(0, 4)));
                do_send("rnd_send", 4'($urandom_range(0, 15)), AW'($urandom), LW'($urandom));
            end else begin
                case ($urandom_range(0, 5))
                    0: rt = INIT;
                    1: rt = ACK;
                    2: rt = NAK;
                    3: rt = DATA0;
                    4: rt = DATA1;
                    default: rt = ERROR;
                endcase
                do_read("rnd_read", rt, $urandom_range(0, 3) == 0);
            end
        end

        bus.fs_send = 1'b1; bus.send_btype = DATA1; bus.ram_addr_init = 12'h555; bus.send_dlen = 12'h0aa;
        n = 0;
        while (!bus.fs_tx && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_in_send_data", 32'(bus.fs_tx), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        bus.fs_send = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_data_m = INIT;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({bus.fd_send, bus.fs_read, bus.fs_tx}), 32'd0);
        end
        do_read("post_rst_d1", DATA1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
